node_frame_serializer: RTL
==========================

Name: node_frame_serializer

Overview:
- Downstream consumer of the chain-simulation cores.
- Takes the flattened per-node position buses (x/y, 32 bits per node) on a frame tick and captures the whole chain in one cycle.
- Streams the captured nodes out one per handshake, in order, over a valid/ready interface to the display/host link.
- Decouples the free-running node update from a slower consumer, and counts frames lost to back-pressure.

Parameters:
- NODE_COUNT, 5, total nodes captured per frame (cores × nodes per core).
- COORD_W, 32, width of one coordinate.
- IDX_W, 8, width of out_index; must satisfy 2^IDX_W ≥ NODE_COUNT.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low; reset==0 at a rising edge of clk resets the block.
- nodes_x  input  NODE_COUNT*COORD_W  node x positions; node i occupies bits [(i+1)*COORD_W-1 : i*COORD_W].
- nodes_y  input  NODE_COUNT*COORD_W  node y positions; same packing as nodes_x.
- frame_tick  input  1  single-cycle request to capture and send one frame.
- out_valid  output  1  stream data valid.
- out_ready  input  1  consumer accepts the current beat.
- out_x  output  COORD_W  captured x of node out_index.
- out_y  output  COORD_W  captured y of node out_index.
- out_index  output  IDX_W  node number of the current beat, 0..NODE_COUNT-1.
- out_last  output  1  high on the beat with out_index == NODE_COUNT-1.
- busy  output  1  high while a frame is being streamed.
- overrun_count  output  16  frame_ticks dropped because the block was busy; saturates.
- dup_count  output  16  frames suppressed by dedup; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset values: out_valid=0, out_index=0, out_last=0, busy=0, out_x=0, out_y=0, overrun_count=0, dup_count=0, snapshot buffer=0, state=IDLE.
- Reset has priority over all other events, including mid-frame; the frame in progress is abandoned.
- States: IDLE and SEND.
- IDLE, frame_tick=1:
  - All NODE_COUNT x/y pairs are latched into the snapshot buffer at that edge.
  - State moves to SEND with out_index=0.
  - out_valid=1 in the next cycle, so latency is 1 cycle from tick to first beat.
- SEND beat rules:
  - out_x/out_y = buffer[out_index].
  - A beat completes on out_valid && out_ready at a rising edge.
  - While out_valid && !out_ready, out_x, out_y, out_index and out_last hold stable and out_valid stays high.
  - On a completed non-last beat, out_index increments.
  - On a completed last beat with no tick in the same cycle: state=IDLE, out_valid=0, out_index=0.
- Tick coinciding with the final handshake: recapture at that edge and stay in SEND with out_index=0. This gives back-to-back frames with no bubble and is not counted as an overrun.
- Tick in SEND at any other time: ignored for capture; overrun_count increments, saturating at 0xFFFF.
- Capture isolation: changes on nodes_x/nodes_y during SEND do not affect the streamed data.
- busy equals (state==SEND).
- out_last is derived from the registered out_index, so it is valid in the same cycle as the beat.
- NODE_COUNT=1: every beat is the last beat, and out_last=1 whenever out_valid=1.

Optional Feature:
- Macro: NODE_FRAME_DEDUP_EN.
- Defined:
  - The block keeps a copy of the last frame actually sent, plus a has_sent flag (cleared by reset).
  - On an IDLE tick where has_sent=1 and incoming nodes_x/nodes_y equal the stored copy, no frame is sent: state stays IDLE and dup_count increments, saturating at 0xFFFF.
  - The comparison uses the combinational inputs in the tick cycle.
  - The dedup check also applies to a tick coinciding with the final handshake.
- Undefined: every accepted tick sends a frame; dup_count is tied to 0 and no compare logic or copy storage exists.

Decomposition:
- Shared package holds:
  - COORD_W default and the coordinate typedef (logic [COORD_W-1:0]).
  - The state enum {IDLE, SEND}.
  - Saturating-counter width (16) and the counter max constant.
- One sub-module, node_snapshot_buf: NODE_COUNT-entry x/y register bank with a one-cycle load-all strobe and an indexed read port. Under NODE_FRAME_DEDUP_EN it also provides the equality-compare output.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release, no tick. Expect out_valid=0, busy=0, both counters 0 for 20 cycles.
- Basic frame:
  - NODE_COUNT=5, nodes_x[i]=0x100+i, nodes_y[i]=0x200+i, out_ready=1, tick at cycle 10.
  - Expect beats at cycles 11–15, index 0..4, x 0x100..0x104, y 0x200..0x204, out_last only at index 4, out_valid=0 at cycle 16.
- Back-pressure:
  - out_ready=0 for 3 cycles on index 2.
  - Expect index 2 data stable for 4 cycles, then the frame completes in order.
  - Change nodes_x mid-frame; streamed values stay unchanged.
- Overrun and back-to-back:
  - Tick during index 1; expect overrun_count=1 and the current frame unchanged.
  - Tick on the index-4 handshake; expect index 0 of the new frame on the next cycle, overrun_count still 1.
  - Apply 70000 busy ticks; overrun_count=0xFFFF.
- Reset mid-frame: reset=0 at index 3; next cycle out_valid=0, out_index=0, counters=0; a subsequent tick restarts at index 0.
- Dedup (macro defined): send a frame, tick again with identical inputs. Expect no out_valid and dup_count=1. Change nodes_y[0] by 1 and tick; expect a full 5-beat frame.

Source files
------------

// File: rtl/node_frame_serializer_pkg.sv
// Shared types and constants for the node frame serializer.
// Dedup feature (NODE_FRAME_DEDUP_EN) is selected in the modules that import this.
package node_frame_serializer_pkg;

    localparam int COORD_W_DEF = 32;

    typedef logic [COORD_W_DEF-1:0] coord_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/node_snapshot_buf.sv
// Per-node x/y register bank: load-all strobe, indexed read port.
// With NODE_FRAME_DEDUP_EN, also compares the live inputs against the bank.
module node_snapshot_buf
    import node_frame_serializer_pkg::*;
#(
    parameter int NODE_COUNT = 5,
    parameter int COORD_W    = COORD_W_DEF,
    parameter int IDX_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [NODE_COUNT*COORD_W-1:0] nodes_x,
    input  logic [NODE_COUNT*COORD_W-1:0] nodes_y,
    input  logic [IDX_W-1:0]              rd_idx,
`ifdef NODE_FRAME_DEDUP_EN
    output logic                          same,
`endif
    output logic [COORD_W-1:0]            rd_x,
    output logic [COORD_W-1:0]            rd_y
);

    logic [COORD_W-1:0] x_q [NODE_COUNT];
    logic [COORD_W-1:0] y_q [NODE_COUNT];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NODE_COUNT; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NODE_COUNT; i++) begin
                x_q[i] <= nodes_x[i*COORD_W +: COORD_W];
                y_q[i] <= nodes_y[i*COORD_W +: COORD_W];
            end
        end
    end

    always_comb begin
        rd_x = '0;
        rd_y = '0;
        for (int i = 0; i < NODE_COUNT; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_x = x_q[i];
                rd_y = y_q[i];
            end
        end
    end

`ifdef NODE_FRAME_DEDUP_EN
    // The bank only ever holds a frame that was (or is being) sent.
    always_comb begin
        same = 1'b1;
        for (int i = 0; i < NODE_COUNT; i++) begin
            if (x_q[i] != nodes_x[i*COORD_W +: COORD_W] ||
                y_q[i] != nodes_y[i*COORD_W +: COORD_W])
                same = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/node_frame_serializer.sv
// Captures the whole node chain on frame_tick and streams it one node per beat.
// Optional NODE_FRAME_DEDUP_EN suppresses frames identical to the last one sent.
module node_frame_serializer
    import node_frame_serializer_pkg::*;
#(
    parameter int NODE_COUNT = 5,
    parameter int COORD_W    = COORD_W_DEF,
    parameter int IDX_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NODE_COUNT*COORD_W-1:0] nodes_x,
    input  logic [NODE_COUNT*COORD_W-1:0] nodes_y,
    input  logic                          frame_tick,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COORD_W-1:0]            out_x,
    output logic [COORD_W-1:0]            out_y,
    output logic [IDX_W-1:0]              out_index,
    output logic                          out_last,
    output logic                          busy,
    output logic [CNT_W-1:0]              overrun_count,
    output logic [CNT_W-1:0]              dup_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODE_COUNT - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] ovr_q, ovr_d;

    logic fire, done, tick_ok, dup_hit, capture;

`ifdef NODE_FRAME_DEDUP_EN
    logic             same;
    logic             has_sent_q;
    logic [CNT_W-1:0] dup_q;
`endif

    node_snapshot_buf #(
        .NODE_COUNT(NODE_COUNT),
        .COORD_W   (COORD_W),
        .IDX_W     (IDX_W)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .load   (capture),
        .nodes_x(nodes_x),
        .nodes_y(nodes_y),
        .rd_idx (idx_q),
`ifdef NODE_FRAME_DEDUP_EN
        .same   (same),
`endif
        .rd_x   (out_x),
        .rd_y   (out_y)
    );

    assign fire    = (state_q == SEND) && out_ready;
    assign done    = fire && (idx_q == LAST_IDX);
    assign tick_ok = frame_tick && ((state_q == IDLE) || done);

`ifdef NODE_FRAME_DEDUP_EN
    assign dup_hit = tick_ok && has_sent_q && same;
`else
    assign dup_hit = 1'b0;
`endif

    assign capture = tick_ok && !dup_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ovr_q   <= ovr_d;
        end
    end

    // A tick on the final handshake restarts without a bubble.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ovr_d   = ovr_q;
        if (capture) begin
            state_d = SEND;
            idx_d   = '0;
        end else if (done) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (fire) begin
            idx_d = idx_q + 1'b1;
        end
        if (frame_tick && (state_q == SEND) && !done)
            ovr_d = sat_inc(ovr_q);
    end

`ifdef NODE_FRAME_DEDUP_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            has_sent_q <= 1'b0;
            dup_q      <= '0;
        end else begin
            if (capture)
                has_sent_q <= 1'b1;
            if (dup_hit)
                dup_q <= sat_inc(dup_q);
        end
    end
    assign dup_count = dup_q;
`else
    assign dup_count = '0;
`endif

    assign out_valid     = (state_q == SEND);
    assign busy          = (state_q == SEND);
    assign out_index     = idx_q;
    assign out_last      = out_valid && (idx_q == LAST_IDX);
    assign overrun_count = ovr_q;

endmodule
